// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode codes, channel
// state encoding and a width helper.
package led_blink_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_ON     = 2'd1,
        S_PH_ON  = 2'd2,
        S_PH_OFF = 2'd3
    } ch_state_e;

    // ceil(log2(value)), never less than 1 so single-entry selects stay legal
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: OFF/ON/BLINK/BURST state machine advanced by the shared tick.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int unsigned TIME_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              load,
    input  logic [1:0]        mode,
    input  logic [TIME_W-1:0] on_t,
    input  logic [TIME_W-1:0] off_t,
    input  logic [CNT_W-1:0]  count,
    output logic              lit,
    output logic              busy
);

    localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    ch_state_e         state_q, state_d;
    logic [TIME_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [TIME_W-1:0] on_t_q, on_t_d;
    logic [TIME_W-1:0] off_t_q, off_t_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              burst_q, burst_d;

    // Next state: a load always wins over a coincident tick
    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        on_t_d   = on_t_q;
        off_t_d  = off_t_q;
        rem_d    = rem_q;
        burst_d  = burst_q;
        if (load) begin
            ph_cnt_d = '0;
            // zero-length phases are stretched to one tick
            on_t_d   = (on_t == '0) ? TIME_ONE : on_t;
            off_t_d  = (off_t == '0) ? TIME_ONE : off_t;
            rem_d    = count;
            burst_d  = (mode == MODE_BURST);
            unique case (mode)
                MODE_OFF:   state_d = S_OFF;
                MODE_ON:    state_d = S_ON;
                MODE_BLINK: state_d = S_PH_ON;
                MODE_BURST: state_d = (count == '0) ? S_OFF : S_PH_ON;
            endcase
        end else if (tick) begin
            unique case (state_q)
                S_PH_ON: begin
                    if (ph_cnt_q == on_t_q - TIME_ONE) begin
                        state_d  = S_PH_OFF;
                        ph_cnt_d = '0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + TIME_ONE;
                    end
                end
                S_PH_OFF: begin
                    if (ph_cnt_q == off_t_q - TIME_ONE) begin
                        ph_cnt_d = '0;
                        if (burst_q) begin
                            rem_d   = rem_q - CNT_ONE;
                            state_d = (rem_q == CNT_ONE) ? S_OFF : S_PH_ON;
                        end else begin
                            state_d = S_PH_ON;
                        end
                    end else begin
                        ph_cnt_d = ph_cnt_q + TIME_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            ph_cnt_q <= '0;
            on_t_q   <= TIME_ONE;
            off_t_q  <= TIME_ONE;
            rem_q    <= '0;
            burst_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            on_t_q   <= on_t_d;
            off_t_q  <= off_t_d;
            rem_q    <= rem_d;
            burst_q  <= burst_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        lit  = (state_q == S_ON) || (state_q == S_PH_ON);
        busy = burst_q && ((state_q == S_PH_ON) || (state_q == S_PH_OFF));
    end

endmodule

// File: rtl/led_blinker_multi.sv
// N-channel LED pattern generator: free-running tick prescaler, config port
// decode to per-channel loads, and LED pin polarity.
module led_blinker_multi
    import led_blink_pkg::*;
#(
    parameter int unsigned  CLK_HZ         = 50_000_000,
    parameter int unsigned  TICK_HZ        = 1_000,
    parameter int unsigned  N_CH           = 4,
    parameter int unsigned  TIME_W         = 16,
    parameter int unsigned  CNT_W          = 8,
    parameter bit           LED_ACTIVE_LOW = 1'b0,
    localparam int unsigned CH_W           = clog2_min1(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [TIME_W-1:0] cfg_on_t,
    input  logic [TIME_W-1:0] cfg_off_t,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   busy,
    output logic              tick
);

    localparam int unsigned      DIV_RAW = CLK_HZ / TICK_HZ;
    localparam int unsigned      DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned      PRE_W   = clog2_min1(DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick_q;
    logic             cfg_ready_q;
    logic             accept;
    logic [N_CH-1:0]  load;
    logic [N_CH-1:0]  lit;
    logic [N_CH-1:0]  ch_busy;

    // Prescaler wraps at DIV-1 and is never restarted by configuration
    always_comb begin
        presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + PRE_W'(1);
    end

    // Tick is registered so it reads 0 in reset and is high while presc_q == DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            tick_q      <= (presc_d == PRE_MAX);
            cfg_ready_q <= 1'b1;
        end
    end

    // Channel select; out-of-range channel numbers are accepted and dropped
    always_comb begin
        accept = cfg_valid && cfg_ready_q;
        load   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            load[i] = accept && (32'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_blink_channel #(
            .TIME_W (TIME_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick_q),
            .load  (load[g]),
            .mode  (cfg_mode),
            .on_t  (cfg_on_t),
            .off_t (cfg_off_t),
            .count (cfg_count),
            .lit   (lit[g]),
            .busy  (ch_busy[g])
        );
    end

    // Pin drive and status outputs
    always_comb begin
        led       = lit ^ {N_CH{LED_ACTIVE_LOW}};
        busy      = ch_busy;
        tick      = tick_q;
        cfg_ready = cfg_ready_q;
    end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Directed self-checking bench for led_blinker_multi (DIV = 10, 4 channels),
// plus a 5-channel active-low instance for polarity and out-of-range channel checks.
module tb_led_blinker_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_on_t = '0;
    logic [15:0] cfg_off_t = '0;
    logic [7:0]  cfg_count = '0;
    logic [3:0]  led;
    logic [3:0]  busy;
    logic        tick;

    logic        cfg2_valid = 1'b0;
    logic        cfg2_ready;
    logic [2:0]  cfg2_ch = '0;
    logic [4:0]  led2;
    logic [4:0]  busy2;
    logic        tick2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    led_blinker_multi #(
        .CLK_HZ (1000), .TICK_HZ (100), .N_CH (4), .TIME_W (16), .CNT_W (8),
        .LED_ACTIVE_LOW (1'b0)
    ) dut (
        .clk (clk), .rst_n (rst_n), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
        .cfg_ch (cfg_ch), .cfg_mode (cfg_mode), .cfg_on_t (cfg_on_t),
        .cfg_off_t (cfg_off_t), .cfg_count (cfg_count), .led (led), .busy (busy),
        .tick (tick)
    );

    led_blinker_multi #(
        .CLK_HZ (1000), .TICK_HZ (100), .N_CH (5), .TIME_W (16), .CNT_W (8),
        .LED_ACTIVE_LOW (1'b1)
    ) dut2 (
        .clk (clk), .rst_n (rst_n), .cfg_valid (cfg2_valid), .cfg_ready (cfg2_ready),
        .cfg_ch (cfg2_ch), .cfg_mode (cfg_mode), .cfg_on_t (cfg_on_t),
        .cfg_off_t (cfg_off_t), .cfg_count (cfg_count), .led (led2), .busy (busy2),
        .tick (tick2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [15:0] on_t, input logic [15:0] off_t,
                            input logic [7:0] cnt);
        cfg_ch = ch; cfg_mode = mode; cfg_on_t = on_t; cfg_off_t = off_t; cfg_count = cnt;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    // Leaves the bench at a sample point where tick is high (next edge sees the tick)
    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (tick !== 1'b1) begin
            total++; bad++;
            $display("FAIL wait_tick: no tick within 30 clk, got %b want 1", tick);
        end
    endtask

    // Count consecutive samples of led[ch] at the given level
    task automatic measure(input int ch, input logic level, output int n);
        n = 0;
        while (led[ch] === level && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int p;
        rst_n = 1'b0;
        step(); step();
        total++; if (led !== 4'h0) begin bad++; $display("FAIL reset_led: got %h want 0", led); end
        total++; if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
        total++; if (led2 !== 5'h1F) begin bad++; $display("FAIL reset_led_active_low: got %h want 1f", led2); end
        rst_n = 1'b1;
        #1;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", cfg_ready); end
        step();
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b want 1", cfg_ready); end
        p = 1;
        while (tick !== 1'b1 && p < 30) begin step(); p++; end
        total++; if (p != 9) begin bad++; $display("FAIL first_tick: got %0d edges want 9", p); end
        p = 0;
        do begin step(); p++; end while (tick !== 1'b1 && p < 30);
        total++; if (p != 10) begin bad++; $display("FAIL tick_period: got %0d want 10", p); end
    endtask

    task automatic test_blink();
        int n;
        send_cfg(2'd0, 2'd2, 16'd3, 16'd2, 8'd0);
        total++; if (led[0] !== 1'b1) begin bad++; $display("FAIL blink_lit_after_accept: got %b want 1", led[0]); end
        total++; if (led[3:1] !== 3'b000) begin bad++; $display("FAIL blink_others: got %b want 000", led[3:1]); end
        measure(0, 1'b1, n);
        total++; if (n < 21 || n > 30) begin bad++; $display("FAIL blink_first_on: got %0d want 21..30", n); end
        measure(0, 1'b0, n);
        total++; if (n != 20) begin bad++; $display("FAIL blink_off: got %0d want 20", n); end
        measure(0, 1'b1, n);
        total++; if (n != 30) begin bad++; $display("FAIL blink_on: got %0d want 30", n); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL blink_busy: got %b want 0", busy[0]); end
        measure(0, 1'b0, n);
        total++; if (n != 20) begin bad++; $display("FAIL blink_off2: got %0d want 20", n); end
        total++; if (led[3:1] !== 3'b000) begin bad++; $display("FAIL blink_others_end: got %b want 000", led[3:1]); end
    endtask

    task automatic test_burst();
        int n;
        int hits;
        wait_tick();
        send_cfg(2'd2, 2'd3, 16'd1, 16'd1, 8'd3);
        total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL burst_busy_start: got %b want 1", busy[2]); end
        for (int k = 0; k < 3; k++) begin
            measure(2, 1'b1, n);
            total++; if (n != 10) begin bad++; $display("FAIL burst_pulse%0d: got %0d want 10", k, n); end
            if (k < 2) begin
                measure(2, 1'b0, n);
                total++; if (n != 10) begin bad++; $display("FAIL burst_gap%0d: got %0d want 10", k, n); end
            end
        end
        n = 0;
        while (busy[2] === 1'b1 && n < 100) begin n++; step(); end
        total++; if (n != 10) begin bad++; $display("FAIL burst_last_dark_busy: got %0d want 10", n); end
        total++; if (led[2] !== 1'b0) begin bad++; $display("FAIL burst_end_led: got %b want 0", led[2]); end
        hits = 0;
        for (int k = 0; k < 30; k++) begin step(); if (led[2] !== 1'b0) hits++; end
        total++; if (hits != 0) begin bad++; $display("FAIL burst_extra_pulse: got %0d lit clk want 0", hits); end
        send_cfg(2'd2, 2'd3, 16'd1, 16'd1, 8'd0);
        hits = 0;
        for (int k = 0; k < 30; k++) begin
            if (led[2] !== 1'b0 || busy[2] !== 1'b0) hits++;
            step();
        end
        total++; if (hits != 0) begin bad++; $display("FAIL burst_count0: got %0d active clk want 0", hits); end
    endtask

    task automatic test_on_off();
        int hits;
        send_cfg(2'd1, 2'd2, 16'd1, 16'd5, 8'd0);
        repeat (15) step();
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL onoff_dark_phase: got %b want 0", led[1]); end
        cfg_ch = 2'd1; cfg_mode = 2'd1; cfg_valid = 1'b1;
        #1;
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL on_latency: got %b want 0", led[1]); end
        step();
        cfg_valid = 1'b0;
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL on_effect: got %b want 1", led[1]); end
        hits = 0;
        for (int k = 0; k < 60; k++) begin step(); if (led[1] !== 1'b1) hits++; end
        total++; if (hits != 0) begin bad++; $display("FAIL on_steady: got %0d dark clk want 0", hits); end
        send_cfg(2'd1, 2'd2, 16'd5, 16'd1, 8'd0);
        repeat (15) step();
        total++; if (led[1] !== 1'b1) begin bad++; $display("FAIL onoff_lit_phase: got %b want 1", led[1]); end
        send_cfg(2'd1, 2'd0, 16'd5, 16'd1, 8'd0);
        total++; if (led[1] !== 1'b0) begin bad++; $display("FAIL off_effect: got %b want 0", led[1]); end
        hits = 0;
        for (int k = 0; k < 60; k++) begin step(); if (led[1] !== 1'b0) hits++; end
        total++; if (hits != 0) begin bad++; $display("FAIL off_steady: got %0d lit clk want 0", hits); end
    endtask

    task automatic test_zero_times();
        int n;
        wait_tick();
        send_cfg(2'd3, 2'd2, 16'd0, 16'd0, 8'd0);
        measure(3, 1'b1, n);
        total++; if (n != 10) begin bad++; $display("FAIL zero_on: got %0d want 10", n); end
        measure(3, 1'b0, n);
        total++; if (n != 10) begin bad++; $display("FAIL zero_off: got %0d want 10", n); end
        measure(3, 1'b1, n);
        total++; if (n != 10) begin bad++; $display("FAIL zero_on2: got %0d want 10", n); end
        send_cfg(2'd3, 2'd0, 16'd0, 16'd0, 8'd0);
    endtask

    task automatic test_accept_on_tick();
        int n;
        wait_tick();
        send_cfg(2'd1, 2'd2, 16'd2, 16'd1, 8'd0);
        measure(1, 1'b1, n);
        total++; if (n != 20) begin bad++; $display("FAIL tick_accept_on: got %0d want 20", n); end
        measure(1, 1'b0, n);
        total++; if (n != 10) begin bad++; $display("FAIL tick_accept_off: got %0d want 10", n); end
        send_cfg(2'd1, 2'd0, 16'd0, 16'd0, 8'd0);
    endtask

    task automatic test_bad_channel();
        cfg2_ch = 3'd5; cfg_mode = 2'd1; cfg2_valid = 1'b1;
        step();
        cfg2_valid = 1'b0;
        step();
        total++; if (led2 !== 5'h1F) begin bad++; $display("FAIL bad_ch_led: got %h want 1f", led2); end
        total++; if (busy2 !== 5'h00) begin bad++; $display("FAIL bad_ch_busy: got %h want 0", busy2); end
        cfg2_ch = 3'd0; cfg_mode = 2'd1; cfg2_valid = 1'b1;
        step();
        cfg2_valid = 1'b0;
        total++; if (led2 !== 5'h1E) begin bad++; $display("FAIL active_low_on: got %h want 1e", led2); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int hits;
        wait_tick();
        send_cfg(2'd2, 2'd3, 16'd2, 16'd2, 8'd5);
        repeat (25) step();
        total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL midburst_busy: got %b want 1", busy[2]); end
        rst_n = 1'b0;
        #1;
        total++; if (led !== 4'h0) begin bad++; $display("FAIL async_rst_led: got %h want 0", led); end
        total++; if (busy !== 4'h0) begin bad++; $display("FAIL async_rst_busy: got %h want 0", busy); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL async_rst_ready: got %b want 0", cfg_ready); end
        total++; if (led2 !== 5'h1F) begin bad++; $display("FAIL async_rst_led2: got %h want 1f", led2); end
        step(); step();
        rst_n = 1'b1;
        step();
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rerst_ready: got %b want 1", cfg_ready); end
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            if (led !== 4'h0 || busy !== 4'h0) hits++;
            step();
        end
        total++; if (hits != 0) begin bad++; $display("FAIL rerst_idle: got %0d active clk want 0", hits); end
        wait_tick();
        send_cfg(2'd2, 2'd3, 16'd1, 16'd1, 8'd1);
        total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL restart_busy: got %b want 1", busy[2]); end
        measure(2, 1'b1, n);
        total++; if (n != 10) begin bad++; $display("FAIL restart_pulse: got %0d want 10", n); end
        n = 0;
        while (busy[2] === 1'b1 && n < 100) begin n++; step(); end
        total++; if (n != 10) begin bad++; $display("FAIL restart_dark: got %0d want 10", n); end
        total++; if (led[2] !== 1'b0) begin bad++; $display("FAIL restart_end_led: got %b want 0", led[2]); end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_burst();
        test_on_off();
        test_zero_times();
        test_accept_on_tick();
        test_bad_channel();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
